// File: rtl/tdc_readout_pkg.sv
// tdc_readout_pkg
// Shared constants for the TDC readout path.
//   - FSM state encoding for the frame sequencer
//   - default frame sync byte
//   - UART 8N1 framing constants
//   - nb_bytes(): number of whole bytes needed to carry a result word
package tdc_readout_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_SYNC = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_CSUM = 3'd4;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;
  localparam logic UART_IDLE_BIT  = 1'b1;
  localparam int   UART_BITS_PER_BYTE = 10;

  function automatic int nb_bytes(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/tdc_readout_uart_tx.sv
// uart_tx_byte
// Transmits one byte as UART 8N1: start bit, 8 data bits LSB first, stop bit.
// Ports:
//   clk     in   clock
//   iRst_n  in   synchronous active-low reset
//   iStart  in   load iByte and start a byte (accepted when idle or on oDone)
//   iByte   in   byte to send
//   oTx     out  serial line, idle high
//   oDone   out  one-cycle strobe in the last cycle of the stop bit
//   oBusy   out  a byte is being shifted out
module uart_tx_byte
  import tdc_readout_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       iRst_n,
  input  logic       iStart,
  input  logic [7:0] iByte,
  output logic       oTx,
  output logic       oDone,
  output logic       oBusy
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(UART_BITS_PER_BYTE - 1);

  logic [BW-1:0] baud_reg;
  logic [3:0]    bit_reg;
  logic [8:0]    shift_reg;   // remaining bits: data bits then stop bit
  logic          tx_reg;
  logic          busy_reg;
  logic          bit_end;

  assign bit_end = busy_reg && (baud_reg == BAUD_LAST);
  // Done is combinational so the next byte can be started on the same edge
  // the stop bit ends, giving back-to-back bytes with no idle gap.
  assign oDone = bit_end && (bit_reg == BIT_LAST);
  assign oTx   = tx_reg;
  assign oBusy = busy_reg;

  always_ff @(posedge clk) begin
    if (!iRst_n) begin
      tx_reg    <= UART_IDLE_BIT;
      busy_reg  <= 1'b0;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
    end else if (iStart && (!busy_reg || oDone)) begin
      tx_reg    <= UART_START_BIT;
      shift_reg <= {UART_STOP_BIT, iByte};
      baud_reg  <= '0;
      bit_reg   <= '0;
      busy_reg  <= 1'b1;
    end else if (busy_reg) begin
      if (bit_end) begin
        baud_reg <= '0;
        if (oDone) begin
          busy_reg <= 1'b0;
          tx_reg   <= UART_IDLE_BIT;
        end else begin
          bit_reg   <= bit_reg + 1'b1;
          tx_reg    <= shift_reg[0];
          shift_reg <= {UART_IDLE_BIT, shift_reg[8:1]};
        end
      end else begin
        baud_reg <= baud_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tdc_readout.sv
// tdc_readout
// Buffers TDC result words in a small FIFO and sends each one to the host
// as a UART frame: SYNC_BYTE, data bytes (MSB first), XOR checksum of data.
// Ports:
//   clk        in   clock
//   iRst_n     in   synchronous active-low reset
//   iData      in   TDC result word
//   iValid     in   single-cycle strobe qualifying iData
//   iClearOvf  in   clears the sticky overflow flag
//   oTx        out  UART serial line, idle high
//   oBusy      out  frame in progress or FIFO non-empty (registered)
//   oLevel     out  FIFO occupancy
//   oOverflow  out  sticky: a word was dropped because the FIFO was full
module tdc_readout
  import tdc_readout_pkg::*;
#(
  parameter int         DATA_W       = 32,
  parameter int         FIFO_DEPTH   = 16,
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic                        clk,
  input  logic                        iRst_n,
  input  logic [DATA_W-1:0]           iData,
  input  logic                        iValid,
  input  logic                        iClearOvf,
  output logic                        oTx,
  output logic                        oBusy,
  output logic [$clog2(FIFO_DEPTH):0] oLevel,
  output logic                        oOverflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NB = nb_bytes(DATA_W);
  localparam int SW = NB * 8;
  localparam int CW = $clog2(NB + 1);
  localparam logic [AW:0]   DEPTH_L = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] NB_L    = CW'(NB);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]       level, level_next;
  logic [DATA_W-1:0] rd_data_reg;
  logic              full, empty, pop, push;
  logic              ovf_reg, busy_reg;

  logic [2:0]        state_reg, state_next;
  logic [SW-1:0]     shift_reg;
  logic [7:0]        csum_reg, csum_next;
  logic [CW-1:0]     cnt_reg;
  logic [SW-1:0]     ext_word;
  logic [7:0]        word_bytes [NB];

  logic              uart_start, uart_done, uart_busy;
  logic [7:0]        uart_byte;

  // ---------------- FIFO ----------------
  // Pointers carry one extra bit so full and empty are distinguishable.
  assign level = wr_ptr_reg - rd_ptr_reg;
  assign full  = (level == DEPTH_L);
  assign empty = (level == '0);
  assign pop   = (state_reg == ST_IDLE) && !empty;
  // A pop in the same cycle frees a slot, so a write while full still lands.
  assign push  = iValid && (!full || pop);
  assign level_next = level + (AW + 1)'(push) - (AW + 1)'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= iData;
  end

  always_ff @(posedge clk) begin
    if (pop) rd_data_reg <= mem[rd_ptr_reg[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!iRst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      ovf_reg    <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      // Setting has priority over clearing when both happen together.
      if (iValid && !push) ovf_reg <= 1'b1;
      else if (iClearOvf)  ovf_reg <= 1'b0;
      busy_reg <= (state_next != ST_IDLE) || (level_next != '0);
    end
  end

  // ---------------- frame payload ----------------
  assign ext_word = SW'(rd_data_reg);

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_bytes
      assign word_bytes[gi] = ext_word[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    csum_next = '0;
    for (int i = 0; i < NB; i++) csum_next = csum_next ^ word_bytes[i];
  end

  // ---------------- frame sequencer ----------------
  always_comb begin
    state_next = state_reg;
    uart_start = 1'b0;
    uart_byte  = shift_reg[SW-1 -: 8];
    case (state_reg)
      ST_IDLE: if (!empty) state_next = ST_LOAD;
      ST_LOAD: begin
        if (!uart_busy) begin
          uart_start = 1'b1;
          uart_byte  = SYNC_BYTE;
          state_next = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (uart_done) begin
          uart_start = 1'b1;
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (uart_done) begin
          uart_start = 1'b1;
          if (cnt_reg == NB_L) begin
            uart_byte  = csum_reg;
            state_next = ST_CSUM;
          end
        end
      end
      ST_CSUM: if (uart_done) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!iRst_n) begin
      state_reg <= ST_IDLE;
      shift_reg <= '0;
      csum_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_LOAD && uart_start) begin
        shift_reg <= ext_word;
        csum_reg  <= csum_next;
        cnt_reg   <= '0;
      end else if (uart_start && state_next == ST_DATA) begin
        // A data byte was just handed to the UART; expose the next one.
        shift_reg <= shift_reg << 8;
        cnt_reg   <= cnt_reg + 1'b1;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk   (clk),
    .iRst_n(iRst_n),
    .iStart(uart_start),
    .iByte (uart_byte),
    .oTx   (oTx),
    .oDone (uart_done),
    .oBusy (uart_busy)
  );

  assign oBusy     = busy_reg;
  assign oLevel    = level;
  assign oOverflow = ovf_reg;

endmodule

// File: tb/tb_tdc_readout.sv
// tb_tdc_readout
// Randomised self-checking bench for tdc_readout. Two instances: a 32-bit
// word instance with a 4-deep FIFO, and a 20-bit instance exercising
// zero extension. UART lines are decoded into byte queues and compared with
// frames built from the frame rules.
module tb_tdc_readout;

  localparam int CPB  = 4;
  localparam int FLEN = 6 * 10 * CPB;   // 32-bit frame length in cycles

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;

  logic [31:0] data_a = '0;
  logic        valid_a = 1'b0, clr_a = 1'b0;
  logic        tx_a, busy_a, ovf_a;
  logic [2:0]  level_a;

  logic [19:0] data_b = '0;
  logic        valid_b = 1'b0, clr_b = 1'b0;
  logic        tx_b, busy_b, ovf_b;
  logic [2:0]  level_b;

  logic [7:0]  rx_a[$], rx_b[$], exp_a[$], exp_b[$];
  int          t_a[$], t_b[$];
  int          frm_err = 0;
  int          n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tdc_readout #(.DATA_W(32), .FIFO_DEPTH(4), .CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut_a (
    .clk(clk), .iRst_n(rst_n), .iData(data_a), .iValid(valid_a), .iClearOvf(clr_a),
    .oTx(tx_a), .oBusy(busy_a), .oLevel(level_a), .oOverflow(ovf_a));

  tdc_readout #(.DATA_W(20), .FIFO_DEPTH(4), .CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut_b (
    .clk(clk), .iRst_n(rst_n), .iData(data_b), .iValid(valid_b), .iClearOvf(clr_b),
    .oTx(tx_b), .oBusy(busy_b), .oLevel(level_b), .oOverflow(ovf_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  function automatic logic line(input int which);
    return (which == 0) ? tx_a : tx_b;
  endfunction

  // Samples each bit in its middle, on the falling clock edge.
  task automatic uart_monitor(input int which);
    logic [7:0] b;
    logic       bad, stop_bit;
    int         t0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && line(which) === 1'b0) begin
        t0 = cyc; bad = 1'b0; b = '0; stop_bit = 1'b0;
        for (int s = 1; s <= 9*CPB + CPB/2; s++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) bad = 1'b1;
          if (s == CPB/2 && line(which) !== 1'b0) bad = 1'b1;
          if (s >= CPB + CPB/2 && s < 9*CPB && (s % CPB) == CPB/2) b[s/CPB - 1] = line(which);
          if (s == 9*CPB + CPB/2) stop_bit = line(which);
        end
        if (!bad) begin
          if (stop_bit !== 1'b1) frm_err++;
          if (which == 0) begin rx_a.push_back(b); t_a.push_back(t0); end
          else begin rx_b.push_back(b); t_b.push_back(t0); end
        end
      end
    end
  endtask

  initial uart_monitor(0);
  initial uart_monitor(1);

  // Reference frame: sync, zero-extended word MSB byte first, XOR of data bytes.
  task automatic add_frame(input logic [31:0] w, input int dw, input int which);
    int nb = (dw + 7) / 8;
    logic [31:0] word = (dw >= 32) ? w : (w & ((32'd1 << dw) - 1));
    logic [7:0] bt, cs = 8'h00;
    if (which == 0) exp_a.push_back(8'hA5); else exp_b.push_back(8'hA5);
    for (int i = nb - 1; i >= 0; i--) begin
      bt = 8'((word >> (8*i)) & 32'hFF);
      cs = cs ^ bt;
      if (which == 0) exp_a.push_back(bt); else exp_b.push_back(bt);
    end
    if (which == 0) exp_a.push_back(cs); else exp_b.push_back(cs);
  endtask

  task automatic wait_bytes(input int which, input int n, input int budget);
    int waited = 0;
    while (((which == 0) ? rx_a.size() : rx_b.size()) < n && waited < budget) begin
      tick();
      waited++;
    end
    check("bytes_received", (which == 0) ? rx_a.size() : rx_b.size(), n);
  endtask

  task automatic compare_stream(input int which, input string tag);
    logic [7:0] e;
    while ((which == 0) ? exp_a.size() > 0 : exp_b.size() > 0) begin
      e = (which == 0) ? exp_a.pop_front() : exp_b.pop_front();
      if ((which == 0) ? rx_a.size() == 0 : rx_b.size() == 0) begin
        check({tag, "_missing_byte"}, 32'hFFFF_FFFF, {24'h0, e});
        break;
      end
      check(tag, (which == 0) ? rx_a.pop_front() : rx_b.pop_front(), e);
    end
    exp_a.delete(); exp_b.delete();
    check({tag, "_extra_bytes"}, (which == 0) ? rx_a.size() : rx_b.size(), 0);
  endtask

  task automatic clear_rx();
    rx_a.delete(); rx_b.delete(); t_a.delete(); t_b.delete();
    exp_a.delete(); exp_b.delete();
  endtask

  task automatic push_a(input logic [31:0] w);
    $display("[TB] push a %08h at cycle %0d", w, cyc);
    data_a = w; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
  endtask

  task automatic push_b(input logic [19:0] w);
    $display("[TB] push b %05h at cycle %0d", w, cyc);
    data_b = w; valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
  endtask

  // Frame start spacing: bytes back-to-back, 2 idle cycles between frames.
  task automatic check_spacing(input int nframes, input int first_start);
    if (t_a.size() < 6 * nframes) return;
    check("first_start", t_a[0], first_start);
    for (int f = 0; f < nframes; f++) begin
      check("frame_span", t_a[6*f + 5] - t_a[6*f], 5 * 10 * CPB);
      if (f > 0) check("frame_gap", t_a[6*f] - t_a[6*f - 1], 10 * CPB + 2);
    end
  endtask

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, r;
    logic [31:0] w [7];

    // ---- reset ----
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("reset_tx", tx_a, 1);
    check("reset_busy", busy_a, 0);
    check("reset_level", level_a, 0);
    check("reset_ovf", ovf_a, 0);

    // ---- single word: latency, content, length, busy ----
    clear_rx();
    n = cyc;
    push_a(32'h0001_2345);
    check("level_after_push", level_a, 1);
    wait_until(n + 3 + FLEN - 1);
    check("busy_in_frame", busy_a, 1);
    wait_bytes(0, 6, 400);
    wait_until(n + 3 + FLEN + 2);
    check("busy_after_frame", busy_a, 0);
    check("tx_idle_after_frame", tx_a, 1);
    check_spacing(1, n + 3);
    foreach (exp_a[i]) ;
    exp_a = '{8'hA5, 8'h00, 8'h01, 8'h23, 8'h45, 8'h67};
    compare_stream(0, "frame_12345");

    // ---- random bursts without overflow ----
    for (int round = 0; round < 6; round++) begin
      clear_rx();
      k = $urandom_range(1, 3);
      n = cyc;
      for (int j = 0; j < k; j++) begin
        w[j] = $urandom;
        add_frame(w[j], 32, 0);
        push_a(w[j]);
      end
      check("burst_level", level_a, (k == 1) ? 1 : k - 1);
      check("burst_ovf", ovf_a, 0);
      wait_bytes(0, 6 * k, 260 * k);
      check_spacing(k, n + 3);
      compare_stream(0, "burst_bytes");
      repeat (8) tick();
      check("burst_idle_busy", busy_a, 0);
      check("burst_idle_level", level_a, 0);
    end

    // ---- overflow, clear priority, write during pop while full ----
    clear_rx();
    n = cyc;
    for (int j = 0; j < 6; j++) begin
      w[j] = $urandom;
      if (j < 5) add_frame(w[j], 32, 0);
      push_a(w[j]);
    end
    check("full_level", level_a, 4);
    check("ovf_set", ovf_a, 1);
    clr_a = 1'b1;
    push_a($urandom);
    clr_a = 1'b0;
    check("ovf_set_beats_clear", ovf_a, 1);
    check("full_level_after_drop", level_a, 4);
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    check("ovf_cleared", ovf_a, 0);
    wait_until(n + 3 + FLEN);
    w[6] = $urandom;
    add_frame(w[6], 32, 0);
    push_a(w[6]);
    check("pop_push_level", level_a, 4);
    check("pop_push_ovf", ovf_a, 0);
    wait_bytes(0, 36, 6 * 260);
    check_spacing(6, n + 3);
    compare_stream(0, "fifo_order");
    repeat (8) tick();
    check("drain_busy", busy_a, 0);

    // ---- reset mid data byte ----
    clear_rx();
    n = cyc;
    push_a($urandom);
    push_a($urandom);
    r = n + 3 + 2*10*CPB + 15;
    wait_until(r);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_tx", tx_a, 1);
    check("midrst_level", level_a, 0);
    check("midrst_busy", busy_a, 0);
    repeat (20) tick();
    check("midrst_stays_idle", tx_a, 1);
    check("midrst_no_restart", busy_a, 0);
    wait_until(r + 60);
    clear_rx();
    n = cyc;
    w[0] = $urandom;
    add_frame(w[0], 32, 0);
    push_a(w[0]);
    wait_bytes(0, 6, 400);
    check_spacing(1, n + 3);
    compare_stream(0, "post_reset_frame");

    // ---- 20-bit words: zero extension ----
    clear_rx();
    push_b(20'hABCDE);
    wait_bytes(1, 5, 400);
    exp_b = '{8'hA5, 8'h0A, 8'hBC, 8'hDE, 8'h68};
    compare_stream(1, "frame_abcde");
    for (int j = 0; j < 3; j++) begin
      clear_rx();
      w[j] = $urandom;
      add_frame(w[j], 20, 1);
      push_b(w[j][19:0]);
      wait_bytes(1, 5, 400);
      compare_stream(1, "frame_20b");
    end
    repeat (8) tick();
    check("b_busy_idle", busy_b, 0);
    check("b_ovf", ovf_b, 0);

    check("stop_bits", frm_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tdc_readout.md
Name: tdc_readout

Overview:
Consumer end of the TDC result interface. Captures each finished measurement word (oTDC qualified by the done pulse) into a small FIFO. Each word is then sent to the host over a UART 8N1 serial line as a framed packet. Sits at top level, one instance per TDC, in the TDC clock domain (clk0).

Parameters:
DATA_W, 32, width of one TDC result word (matches `DIG_OUT).
FIFO_DEPTH, 16, result FIFO entries; power of two, minimum 2.
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); minimum 2.
SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
clk  input  1  system clock; all logic on its rising edge.
iRst_n  input  1  reset, synchronous, active-low.
iData  input  DATA_W  TDC result word.
iValid  input  1  single-cycle strobe; iData is valid in the same cycle.
iClearOvf  input  1  synchronous clear of oOverflow.
oTx  output  1  UART serial line; idle high.
oBusy  output  1  high while a frame is in progress or the FIFO is non-empty.
oLevel  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
oOverflow  output  1  sticky flag; set when a word is dropped because the FIFO is full.

Behaviour:
- Reset (iRst_n low at a clk edge): oTx=1, oBusy=0, oLevel=0, oOverflow=0, FIFO pointers cleared, FSM to IDLE, UART bit counter and baud counter cleared. Reset mid-frame aborts the frame immediately; oTx returns high the next cycle, with no partial stop bit.
- Write: iValid=1 and FIFO not full -> push iData, oLevel+1 next cycle.
- Write while full: the word is dropped and oOverflow=1 next cycle. oOverflow holds until iClearOvf=1 or reset. If set and clear fall in the same cycle, set wins.
- Write while full with a pop in the same cycle: the write is accepted and oLevel is unchanged.
- Frame content: NB = ceil(DATA_W/8) data bytes. The word is zero-extended to NB*8 bits and sent most-significant byte first. Sequence is SYNC_BYTE, data bytes, then CSUM = XOR of all data bytes (SYNC excluded). Frame length is NB+2 bytes.
- Byte format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles. Bytes within a frame are back-to-back, with no idle gap between stop bit and next start bit.
- FSM states: IDLE, LOAD, SYNC, DATA, CSUM.
  - IDLE: FIFO not empty -> pop, go to LOAD.
  - LOAD: latch the popped word into a shift register, compute CSUM, go to SYNC.
  - SYNC: send SYNC_BYTE, then go to DATA.
  - DATA: send NB bytes, then go to CSUM.
  - CSUM: send CSUM. On stop-bit completion, go to IDLE.
  - Consecutive frames are separated by exactly 2 idle cycles (IDLE and LOAD).
- Latency: iValid at cycle N with FIFO empty and FSM in IDLE -> pop at N+1, LOAD at N+2, oTx falls (SYNC start bit) at N+3.
- The FIFO accepts writes throughout transmission; reads occur only in IDLE.
- oBusy = (state != IDLE) | (oLevel != 0), registered.
- Pointers wrap modulo FIFO_DEPTH. Full is detected with an extra pointer bit. oLevel saturates at FIFO_DEPTH by construction.

Decomposition:
- tdc_readout_pkg (or a defines include, per team flow): FSM state encoding, SYNC_BYTE default, NB computation function, UART frame constants (start/stop values, 10 bits per byte).
- Sub-module uart_tx_byte: inputs clk, iRst_n, iStart, iByte[7:0]; outputs oTx, oDone (one-cycle strobe at the end of the stop bit), oBusy.
- Keep the FIFO inline as a plain register array; no vendor primitive is needed.

Test Plan:
1. DATA_W=32, CLKS_PER_BIT=4. Push 32'h0001_2345 -> oTx falls 3 cycles after iValid. Decoded bytes are A5 00 01 23 45 67. Frame lasts 6*10*4 = 240 cycles, then oBusy=0.
2. DATA_W=20, push 20'hABCDE -> NB=3. Bytes are A5 0A BC DE, then CSUM 0A^BC^DE = 68.
3. FIFO_DEPTH=4, push 6 words on consecutive cycles while idle -> first popped; 5 remain but depth 4 -> 1 dropped, oOverflow=1. Five frames total are emitted, in order, with 2 idle cycles between frames.
4. With FIFO full, iValid coincident with the IDLE pop -> word accepted, oLevel stays 4, oOverflow stays 0.
5. Assert iRst_n=0 for 1 cycle mid DATA byte -> oTx=1 next cycle, oLevel=0, FSM IDLE. A new push then yields a clean full frame.
6. oOverflow set; assert iClearOvf together with a dropping write -> oOverflow stays 1. iClearOvf alone -> oOverflow=0 next cycle.
